// File: rtl/dout_uart_pkg.sv
// Shared types and frame constants for the dout UART transmitter.
package dout_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned DATA_BITS   = 8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/dout_uart_tx_if.sv
// Core-side write port and status of the dout UART transmitter.
interface dout_uart_tx_if;
  import dout_uart_pkg::*;

  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              full;
  logic              busy;
  logic              overflow;

  modport master (output wr_en, output wr_data, input full, input busy, input overflow);
  modport slave  (input wr_en, input wr_data, output full, output busy, output overflow);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data falls through from the head.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dout_uart_tx.sv
// Buffers 16-bit dout writes and sends each as two 8N1 bytes, low byte first.
module dout_uart_tx
  import dout_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           sys_rst,
  dout_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  logic              rst_n;
  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              byte_sel_q, byte_sel_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q;
  logic              armed_q;
  logic              pop_c;
  logic              bit_end_c;
  logic              wr_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;

  assign rst_n = sys_rst;

  // Writes are ignored until one clock after reset release.
  assign wr_c = bus.wr_en && armed_q;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_c && !fifo_full),
    .wdata (bus.wr_data),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end_c    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign bus.full     = fifo_full;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != IDLE) || !fifo_empty;
  assign tx           = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_sel_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= IDLE_LEVEL;
      ovf_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_sel_q <= byte_sel_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      armed_q    <= 1'b1;
      if (wr_c && fifo_full) ovf_q <= 1'b1;
    end
  end

  // Frame sequencing; the shift register moves right one bit per data bit,
  // so after the low byte the high byte already sits in the bottom 8 bits.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_sel_d = byte_sel_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          shift_d    = fifo_rdata;
          byte_sel_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shift_d = {1'b0, shift_q[WORD_W-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = START;
          end else if (!fifo_empty) begin
            pop_c      = 1'b1;
            shift_d    = fifo_rdata;
            byte_sel_d = 1'b0;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state; registered one clock later.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_q)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_q[0];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

endmodule

// File: doc/dout_uart_tx.md
# dout_uart_tx

Output-side peripheral for the miniRISC core. It captures each 16-bit word the core writes to its `dout` port, buffers the words in a small FIFO, and serializes them as two 8N1 UART bytes, low byte first. It lets a host or a bench watch program results, such as the product 30 from the multiply loop, on a single pin without hierarchical probing of the core.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, 4: number of 16-bit words buffered. Must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `sys_rst` in 1: asynchronous, active-low reset.
- `wr_en` in 1: core output-register write strobe, one cycle per word.
- `wr_data` in 16: the core's `dout` value, qualified by `wr_en`.
- `full` out 1: FIFO holds `FIFO_DEPTH` words.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `overflow` out 1: sticky; a write was dropped.
- `tx` out 1: UART serial line, registered, idles high.

## Operation
- Reset values:
  - `tx` = 1
  - `busy` = 0
  - `full` = 0
  - `overflow` = 0
  - FIFO empty, pointers 0, FSM in IDLE.
- Write side:
  - A write is accepted when `wr_en`=1 and `full`=0.
  - When `wr_en`=1 and `full`=1, the word is dropped and `overflow` is set. `overflow` stays set until reset.
  - `full` is evaluated from the count at the start of the cycle. A pop in the same cycle does not rescue a write to a full FIFO.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH.
  - Full when the MSBs differ and the rest match. Empty when the pointers are equal.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop one word into a 16-bit shift register, set `byte_sel`=0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles. A bit index counts 0..7. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then:
    - If `byte_sel`=0: set `byte_sel`=1, shift in the high byte, go to START.
    - Else, if the FIFO is non-empty: pop the next word and go to START.
    - Else: go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
- `busy` = (state ≠ IDLE) OR FIFO non-empty.

## Timing
- Write latency: a word accepted at edge N is visible in the FIFO after N. The FSM pops it at edge N+1, and `tx` falls after edge N+2 (registered output).
- Frame length:
  - One byte = 10·CLKS_PER_BIT cycles.
  - One word = 20·CLKS_PER_BIT cycles, with no idle gap between its two bytes.
  - Back-to-back words have no idle gap: the stop bit of word k is followed directly by the start bit of word k+1.
- `full` and `overflow` update on the edge of the causing write. The pop edge clears `full`.
- Reset asserted mid-frame:
  - `tx` goes to 1 asynchronously.
  - The FIFO is flushed and the partial frame is abandoned.
  - After release, the block is idle until the next `wr_en`.
- A `wr_en` in the same cycle as reset release is ignored.

## Structure
- Package `dout_uart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - Frame constants: `DATA_BITS`=8, `STOP_LEVEL`=1, `IDLE_LEVEL`=1.
- Sub-module `sync_fifo`, parameterized by width and depth, with push/pop/full/empty. Instanced once at width 16.
- The FSM, baud counter and shift register live in the top of the block.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.

- Reset check: hold `sys_rst`=0 for 5 cycles → `tx`=1, `busy`=0, `full`=0, `overflow`=0.
- Single word: write 0x001E once.
  - `tx` samples per bit: 0, 0 1 1 1 1 0 0 0, 1, then 0, 0 0 0 0 0 0 0 0, 1.
  - `busy` is high for 80 cycles, then drops.
- Back-to-back words: write 0x0005, 0x0006, 0x001E on consecutive cycles.
  - Six bytes are decoded in order: 05 00 06 00 1E 00.
  - There is no idle-high gap longer than one stop bit.
- Overflow: write 6 words on consecutive cycles while the FSM is in IDLE.
  - The first word is popped, so `full` rises after 5 accepts.
  - The 6th write is dropped and `overflow`=1.
  - Exactly 5 words are transmitted, and `overflow` stays 1.
- Reset mid-frame: assert reset during DATA bit 3 of 0xA5A5.
  - `tx`=1 within the same cycle.
  - After release, `busy`=0, and no further falling edge appears on `tx`.
- Simultaneous push/pop: write a word on the exact cycle the FSM pops from a 2-deep FIFO.
  - The count stays 2.
  - All words are transmitted in order.
